// File: rtl/texture_palette_arbiter_pkg.sv
// Shared texture-path types: palette index width, colour channel width and RGB packing.
package tex_pkg;
    localparam int TEX_IDX_W = 8;
    localparam int COLOR_W   = 4;

    typedef struct packed {
        logic [COLOR_W-1:0] red;
        logic [COLOR_W-1:0] green;
        logic [COLOR_W-1:0] blue;
    } rgb12_t;

    typedef struct packed {
        logic                 valid;
        logic [TEX_IDX_W-1:0] index;
    } tex_req_t;

    function automatic rgb12_t pack_rgb(input logic [COLOR_W-1:0] r,
                                        input logic [COLOR_W-1:0] g,
                                        input logic [COLOR_W-1:0] b);
        rgb12_t c;
        c.red   = r;
        c.green = g;
        c.blue  = b;
        return c;
    endfunction
endpackage

// File: rtl/texture_palette_arbiter_if.sv
// Requester, palette ROM and response bundle for the texture palette arbiter.
interface texture_palette_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = tex_pkg::TEX_IDX_W,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    import tex_pkg::*;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*IDX_W-1:0] req_index;
    logic [NUM_REQ-1:0]       req_ready;

    logic [IDX_W-1:0]         pal_index;
    logic [COLOR_W-1:0]       pal_red;
    logic [COLOR_W-1:0]       pal_green;
    logic [COLOR_W-1:0]       pal_blue;

    logic                     rsp_valid;
    logic [ID_W-1:0]          rsp_id;
    logic [NUM_REQ-1:0]       rsp_valid_oh;
    logic [COLOR_W-1:0]       rsp_red;
    logic [COLOR_W-1:0]       rsp_green;
    logic [COLOR_W-1:0]       rsp_blue;

    modport slave (
        input  req_valid, req_index, pal_red, pal_green, pal_blue,
        output req_ready, pal_index, rsp_valid, rsp_id, rsp_valid_oh,
               rsp_red, rsp_green, rsp_blue
    );

    modport master (
        output req_valid, req_index, pal_red, pal_green, pal_blue,
        input  req_ready, pal_index, rsp_valid, rsp_id, rsp_valid_oh,
               rsp_red, rsp_green, rsp_blue
    );
endinterface

// File: rtl/texture_palette_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr_i wins, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    winner_o,
    output logic               any_o
);
    int unsigned idx;

    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        any_o    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (!any_o && req_i[idx]) begin
                any_o        = 1'b1;
                grant_o[idx] = 1'b1;
                winner_o     = ID_W'(idx);
            end
        end
    end
endmodule

// File: rtl/texture_palette_arbiter.sv
// Shares one combinational palette ROM among NUM_REQ requesters; colour returns 2 cycles
// after the grant, tagged with the requester ID.
module texture_palette_arbiter
    import tex_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = TEX_IDX_W,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    texture_palette_arbiter_if.slave   bus
);
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    winner;
    logic               any_req;
    logic               accept;

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   pal_index_q, pal_index_d;
    logic               s1_valid_q, s1_valid_d;
    logic [ID_W-1:0]    s1_id_q, s1_id_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [NUM_REQ-1:0] rsp_valid_oh_q, rsp_valid_oh_d;
    rgb12_t             rsp_rgb_q, rsp_rgb_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req_i    (bus.req_valid),
        .ptr_i    (rr_ptr_q),
        .grant_o  (grant),
        .winner_o (winner),
        .any_o    (any_req)
    );

    // A request seen while reset is high must not look accepted to the requester.
    assign accept        = any_req && !reset_i;
    assign bus.req_ready = reset_i ? '0 : grant;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        pal_index_d = pal_index_q;
        s1_valid_d  = accept;
        s1_id_d     = s1_id_q;
        if (accept) begin
            rr_ptr_d    = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
            pal_index_d = bus.req_index[int'(winner)*IDX_W +: IDX_W];
            s1_id_d     = winner;
        end
    end

    // Colour is captured only for live entries so idle cycles keep the last result.
    always_comb begin
        rsp_valid_d    = s1_valid_q;
        rsp_id_d       = s1_id_q;
        rsp_valid_oh_d = s1_valid_q ? (NUM_REQ'(1) << s1_id_q) : '0;
        rsp_rgb_d      = s1_valid_q ? pack_rgb(bus.pal_red, bus.pal_green, bus.pal_blue)
                                    : rsp_rgb_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr_q       <= '0;
            pal_index_q    <= '0;
            s1_valid_q     <= 1'b0;
            s1_id_q        <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= '0;
            rsp_valid_oh_q <= '0;
            rsp_rgb_q      <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            pal_index_q    <= pal_index_d;
            s1_valid_q     <= s1_valid_d;
            s1_id_q        <= s1_id_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_id_q       <= rsp_id_d;
            rsp_valid_oh_q <= rsp_valid_oh_d;
            rsp_rgb_q      <= rsp_rgb_d;
        end
    end

    assign bus.pal_index    = pal_index_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_valid_oh = rsp_valid_oh_q;
    assign bus.rsp_red      = rsp_rgb_q.red;
    assign bus.rsp_green    = rsp_rgb_q.green;
    assign bus.rsp_blue     = rsp_rgb_q.blue;
endmodule
